// File: rtl/matlab_seq_pkg.sv
// matlab_seq_pkg: shared types and constants for the MATLAB core run sequencer.
// Holds the sequencer state encoding, the default length-field width and the
// core mode codes carried on MATLABconf.
package matlab_seq_pkg;

    // Default width of the run-length field and of every beat counter.
    localparam int LEN_W_DEF = 12;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Core mode as latched from MATLABconf.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_0 = 2'd0;
    localparam mode_t MODE_1 = 2'd1;
    localparam mode_t MODE_2 = 2'd2;
    localparam mode_t MODE_3 = 2'd3;

    // True in the states where beats or results are moving.
    function automatic logic is_active(input state_e s);
        return (s == ST_STREAM) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/matlab_seq_pipe.sv
// matlab_seq_pipe: one-stage registered valid/ready slice carrying data and a
// last flag from the gated sample stream into the MATLAB core.
// A flush drops the held beat (used when a run is abandoned).
module matlab_seq_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              load;

    // The slot can take a new beat when empty or when its beat leaves this cycle.
    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;

    // Next-state of the holding register: flush, load, or drain on handshake.
    always_comb begin
        // NOTE: every comb output is given a default first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (flush_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            last_d  = in_last_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Holding register, cleared asynchronously so an in-flight beat is discarded.
    always_ff @(posedge aclk or posedge areset) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values; blocking '=' is kept to the comb blocks.
        if (areset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/matlab_seq.sv
// matlab_seq: run sequencer for the MATLAB-generated processing core.
// Accepts a Start/conf/length request, gates exactly length sample beats into
// the core through a one-stage slice, tags the last beat, counts result beats
// back, and drives the run-level valid whose falling edge clears APB Busy.
// Optional watchdog: define MATLAB_SEQ_TIMEOUT_EN to abandon a stalled run
// after TIMEOUT_CYC cycles without a beat or result handshake and flag err.
module matlab_seq
    import matlab_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [1:0]        conf,
    input  logic [LEN_W-1:0]  length,
    output logic              valid,
    output logic [1:0]        core_mode,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              s_tready,
    output logic              m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    input  logic              m_tready,
    input  logic              r_tvalid,
    input  logic              r_tready,
    output logic [LEN_W-1:0]  done_cnt,
    output logic              err
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    mode_t            mode_q, mode_d;
    logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0] done_cnt_q, done_cnt_d;

    logic run_accept;
    logic active;
    logic m_hs;
    logic r_hs;
    logic last_m_hs;
    logic s_gate;
    logic s_load;
    logic pipe_ready;
    logic beat_last;
    logic results_done;
    logic timeout_hit;

    assign run_accept   = (state_q == ST_IDLE) && start;
    assign active       = is_active(state_q);
    assign m_hs         = m_tvalid && m_tready;
    assign r_hs         = r_tvalid && r_tready;
    assign last_m_hs    = m_hs && m_tlast;
    assign s_load       = s_tvalid && s_tready;
    // The beat being loaded now is the final one of the run.
    assign beat_last    = (issue_cnt_q == len_q - LEN_W'(1));
    // Uses the next count so a result arriving this cycle is already included.
    assign results_done = (done_cnt_d == len_q);

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (len_q == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                if (timeout_hit) begin
                    state_d = ST_DONE;
                end else if (last_m_hs) begin
                    // Results may already be complete, or complete on this edge.
                    state_d = results_done ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (timeout_hit || results_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state: run-level valid and the sample gate.
    always_comb begin
        valid  = 1'b0;
        s_gate = 1'b0;
        case (state_q)
            ST_LOAD, ST_DRAIN: begin
                valid = 1'b1;
            end
            ST_STREAM: begin
                valid  = 1'b1;
                s_gate = (issue_cnt_q < len_q) && !timeout_hit;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

    // The source is only ready when the gate is open and the slice has room.
    assign s_tready = s_gate && pipe_ready;

    // Run parameters latch on accept; counters clear in LOAD and step on handshakes.
    always_comb begin
        len_d       = len_q;
        mode_d      = mode_q;
        issue_cnt_d = issue_cnt_q;
        done_cnt_d  = done_cnt_q;
        if (run_accept) begin
            len_d  = length;
            mode_d = conf;
        end
        if (state_q == ST_LOAD) begin
            issue_cnt_d = '0;
            done_cnt_d  = '0;
        end
        if (s_load) begin
            issue_cnt_d = issue_cnt_q + LEN_W'(1);
        end
        // Result count saturates at the run length.
        if (active && r_hs && (done_cnt_q < len_q)) begin
            done_cnt_d = done_cnt_q + LEN_W'(1);
        end
    end

    // Run parameter and beat counter registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            len_q       <= '0;
            mode_q      <= MODE_0;
            issue_cnt_q <= '0;
            done_cnt_q  <= '0;
        end else begin
            len_q       <= len_d;
            mode_q      <= mode_d;
            issue_cnt_q <= issue_cnt_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign core_mode = mode_q;
    assign done_cnt  = done_cnt_q;

`ifdef MATLAB_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;
    logic            stall_cycle;

    // A cycle in STREAM/DRAIN with neither a beat nor a result moving.
    assign stall_cycle = active && !m_hs && !r_hs;
    assign timeout_hit = stall_cycle && (wdog_q == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog counts stalled cycles; err is sticky until the next accepted run.
    always_comb begin
        wdog_d = stall_cycle ? (wdog_q + WD_W'(1)) : '0;
        err_d  = err_q;
        if (run_accept) begin
            err_d = 1'b0;
        end else if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    // Watchdog and error registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    // Without the watchdog a stalled core simply holds valid high.
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
    assign err                = 1'b0;
`endif

    // Single-stage slice between the gated sample stream and the core.
    matlab_seq_pipe #(
        .DATA_W(DATA_W)
    ) u_pipe (
        .aclk        (aclk),
        .areset      (areset),
        .in_valid_i  (s_tvalid && s_gate),
        .in_data_i   (s_tdata),
        .in_last_i   (beat_last),
        .in_ready_o  (pipe_ready),
        .flush_i     (timeout_hit),
        .out_valid_o (m_tvalid),
        .out_data_o  (m_tdata),
        .out_last_o  (m_tlast),
        .out_ready_i (m_tready)
    );

endmodule

// File: tb/tb_matlab_seq.sv
// tb_matlab_seq: table-driven bench for matlab_seq, plus hand-written
// sequences for asynchronous reset mid-run and a stalled core.
// Watchdog expectations follow MATLAB_SEQ_TIMEOUT_EN.
module tb_matlab_seq;
    import matlab_seq_pkg::*;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 12;
    localparam int TO_CYC = 64;

    logic              aclk = 1'b0;
    logic              areset;
    logic              start;
    logic [1:0]        conf;
    logic [LEN_W-1:0]  length;
    logic              valid;
    logic [1:0]        core_mode;
    logic              s_tvalid;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tready;
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic              m_tready;
    logic              r_tvalid;
    logic              r_tready;
    logic [LEN_W-1:0]  done_cnt;
    logic              err;

    matlab_seq #(
        .DATA_W      (DATA_W),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .start     (start),
        .conf      (conf),
        .length    (length),
        .valid     (valid),
        .core_mode (core_mode),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .s_tready  (s_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .r_tvalid  (r_tvalid),
        .r_tready  (r_tready),
        .done_cnt  (done_cnt),
        .err       (err)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Bench-side stimulus knobs and observed run statistics.
    int          cyc = 0;
    logic        start_req = 1'b0;
    bit          s_gaps = 1'b0;
    int          m_pat = 0;        // 0: always ready, 1: toggling, 2: stall after stall_after beats
    int          stall_after = 0;
    int          s_idx = 0;
    int          s_lim = 0;
    logic [31:0] s_base = 32'hA000_0000;
    int          exp_len = 0;
    logic [1:0]  exp_mode = 2'd0;
    int          beats = 0;
    int          lasts = 0;
    int          res_pend = 0;
    int          vcyc = 0;
    int          mode_err = 0;
    int          mv_seen = 0;
    bit          v_seen = 1'b0;
    bit          fell = 1'b0;
    int          fall_cyc = 0;
    int          last_hs = 0;

    typedef struct {
        int         len;
        logic [1:0] cf;
        bit         gaps;
        int         mpat;
        int         mid;        // wait-loop index of an extra start pulse, -1 for none
        int         exp_beats;
        int         exp_done;
        int         exp_lasts;
        int         exp_vcyc;   // exact valid-high cycles, 0 = only the len+2 minimum
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, return at the rising edge.
    task automatic cycle();
        @(negedge aclk);
        start    = start_req;
        s_tvalid = (s_idx < s_lim) && (!s_gaps || ($urandom_range(0, 2) != 0));
        s_tdata  = s_base + 32'(s_idx);
        case (m_pat)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 2) == 1;
            default: m_tready = (beats < stall_after);
        endcase
        r_tvalid = (res_pend > 0);
        r_tready = 1'b1;
        #1;
        if (valid) begin
            vcyc++;
            v_seen = 1'b1;
            if (core_mode !== exp_mode) mode_err++;
        end else if (v_seen && !fell) begin
            fell     = 1'b1;
            fall_cyc = cyc;
        end
        if (m_tvalid) mv_seen++;
        if (s_tvalid && s_tready) s_idx++;
        if (m_tvalid && m_tready) begin
            check("m_tdata order", 64'(m_tdata), 64'(s_base + 32'(beats)));
            check("m_tlast position", 64'(m_tlast), 64'(beats == exp_len - 1));
            if (m_tlast) lasts++;
            beats++;
            res_pend++;
            last_hs = cyc;
        end
        if (r_tvalid && r_tready) begin
            res_pend--;
            last_hs = cyc;
        end
        cyc++;
        @(posedge aclk);
    endtask

    task automatic begin_run(input int len, input logic [1:0] cf);
        s_idx    = 0;
        s_lim    = len;
        beats    = 0;
        lasts    = 0;
        res_pend = 0;
        vcyc     = 0;
        mode_err = 0;
        mv_seen  = 0;
        v_seen   = 1'b0;
        fell     = 1'b0;
        exp_len  = len;
        exp_mode = cf;
        s_base   = s_base + 32'h0001_0000;
        length   = LEN_W'(len);
        conf     = cf;
        start_req = 1'b1;
        cycle();
        start_req = 1'b0;
    endtask

    // Run until valid falls, optionally pulsing start with new length/conf mid-run.
    task automatic wait_fall(input int budget, input int mid_start);
        for (int n = 0; n < budget && !fell; n++) begin
            if (n == mid_start) begin
                start_req = 1'b1;
                length    = LEN_W'(3);
                conf      = MODE_2;
            end else begin
                start_req = 1'b0;
            end
            cycle();
        end
        start_req = 1'b0;
        #1;
        check("run ended within budget", 64'(fell), 64'd1);
    endtask

    initial begin
        int v0;

        areset   = 1'b1;
        start    = 1'b0;
        conf     = 2'd0;
        length   = '0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        r_tvalid = 1'b0;
        r_tready = 1'b0;

        tbl[0] = '{8,  MODE_1, 1'b0, 0, -1, 8,  8,  1, 11};
        tbl[1] = '{0,  MODE_2, 1'b0, 0, -1, 0,  0,  0, 1};
        tbl[2] = '{16, MODE_3, 1'b1, 1, -1, 16, 16, 1, 0};
        tbl[3] = '{10, MODE_1, 1'b0, 0, 4,  10, 10, 1, 13};
        tbl[4] = '{1,  MODE_2, 1'b0, 0, -1, 1,  1,  1, 4};
        tbl[5] = '{5,  MODE_0, 1'b1, 0, -1, 5,  5,  1, 0};

        // Reset values, before any clock edge.
        #3;
        check("reset valid", 64'(valid), 64'd0);
        check("reset s_tready", 64'(s_tready), 64'd0);
        check("reset m_tvalid", 64'(m_tvalid), 64'd0);
        check("reset m_tlast", 64'(m_tlast), 64'd0);
        check("reset m_tdata", 64'(m_tdata), 64'd0);
        check("reset core_mode", 64'(core_mode), 64'd0);
        check("reset done_cnt", 64'(done_cnt), 64'd0);
        check("reset err", 64'(err), 64'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            m_pat  = tbl[i].mpat;
            s_gaps = tbl[i].gaps;
            begin_run(tbl[i].len, tbl[i].cf);
            wait_fall(2000, tbl[i].mid);
            check("beat count", 64'(beats), 64'(tbl[i].exp_beats));
            check("m_tlast count", 64'(lasts), 64'(tbl[i].exp_lasts));
            check("done_cnt", 64'(done_cnt), 64'(tbl[i].exp_done));
            check("core_mode stable in run", 64'(mode_err), 64'd0);
            check("core_mode held after run", 64'(core_mode), 64'(tbl[i].cf));
            check("err after run", 64'(err), 64'd0);
            check("m_tvalid after run", 64'(m_tvalid), 64'd0);
            if (tbl[i].exp_vcyc != 0)
                check("valid width", 64'(vcyc), 64'(tbl[i].exp_vcyc));
            else
                check("valid width minimum", 64'(vcyc >= tbl[i].len + 2), 64'd1);
            if (tbl[i].len == 0)
                check("no m_tvalid on zero length", 64'(mv_seen), 64'd0);
            v0 = vcyc;
            repeat (3) cycle();
            check("idle after run", 64'(vcyc - v0), 64'd0);
        end

        // Asynchronous reset mid-STREAM after 5 of 10 beats, then a clean 4-beat run.
        m_pat  = 0;
        s_gaps = 1'b0;
        begin_run(10, MODE_3);
        for (int n = 0; n < 100 && beats < 5; n++) cycle();
        #1;
        check("pre-reset valid", 64'(valid), 64'd1);
        check("pre-reset m_tvalid", 64'(m_tvalid), 64'd1);
        #1;
        areset = 1'b1;
        #1;
        check("async reset valid", 64'(valid), 64'd0);
        check("async reset m_tvalid", 64'(m_tvalid), 64'd0);
        check("async reset s_tready", 64'(s_tready), 64'd0);
        check("async reset m_tdata", 64'(m_tdata), 64'd0);
        check("async reset core_mode", 64'(core_mode), 64'd0);
        check("async reset done_cnt", 64'(done_cnt), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        begin_run(4, MODE_1);
        wait_fall(200, -1);
        check("post-reset beats", 64'(beats), 64'd4);
        check("post-reset m_tlast count", 64'(lasts), 64'd1);
        check("post-reset done_cnt", 64'(done_cnt), 64'd4);
        check("post-reset core_mode", 64'(core_mode), 64'(MODE_1));

        // Core accepts 4 beats and then stalls.
        m_pat       = 2;
        stall_after = 4;
        begin_run(8, MODE_2);
`ifdef MATLAB_SEQ_TIMEOUT_EN
        wait_fall(400, -1);
        check("timeout beats", 64'(beats), 64'd4);
        check("timeout done_cnt", 64'(done_cnt), 64'd4);
        check("timeout err", 64'(err), 64'd1);
        check("timeout m_tvalid dropped", 64'(m_tvalid), 64'd0);
        // Valid goes low TO_CYC edges after the handshake edge; that edge closes
        // the handshake's sample cycle, so the low level is seen TO_CYC+1 samples later.
        check("timeout delay", 64'(fall_cyc - last_hs), 64'(TO_CYC + 1));
        m_pat = 0;
        begin_run(2, MODE_0);
        #1;
        check("err cleared by start", 64'(err), 64'd0);
        wait_fall(200, -1);
        check("after timeout beats", 64'(beats), 64'd2);
        check("after timeout done_cnt", 64'(done_cnt), 64'd2);
`else
        for (int n = 0; n < 150; n++) cycle();
        #1;
        check("stall valid held", 64'(valid), 64'd1);
        check("stall err", 64'(err), 64'd0);
        check("stall m_tvalid held", 64'(m_tvalid), 64'd1);
        check("stall beats", 64'(beats), 64'd4);
        m_pat = 0;
        wait_fall(200, -1);
        check("stall release beats", 64'(beats), 64'd8);
        check("stall release m_tlast count", 64'(lasts), 64'd1);
        check("stall release done_cnt", 64'(done_cnt), 64'd8);
        check("stall release err", 64'(err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global time limit: got no finish expected finish");
        $fatal(1);
    end

endmodule
